// File: rtl/expr_harness_pkg.sv
// Shared types, constants and next-state helpers for the expression vector harness.
package expr_harness_pkg;

  // Run-control states of the harness sequencer.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Galois right-shift feedback taps for the 64-bit stimulus LFSR.
  localparam logic [63:0] LFSR_MASK = 64'hD800_0000_0000_0000;
  // CRC-32 polynomial used as MISR feedback.
  localparam logic [31:0] CRC_POLY  = 32'h04C11DB7;
  // Signature value at the start of every run.
  localparam logic [31:0] MISR_INIT = 32'hFFFF_FFFF;

  // Operand bit-slices of the LFSR state (lsb position and width).
  localparam int A0_LSB = 0;   localparam int A0_W = 4;
  localparam int A1_LSB = 4;   localparam int A1_W = 5;
  localparam int A2_LSB = 9;   localparam int A2_W = 6;
  localparam int A3_LSB = 15;  localparam int A3_W = 4;
  localparam int A4_LSB = 19;  localparam int A4_W = 5;
  localparam int A5_LSB = 24;  localparam int A5_W = 6;
  localparam int B0_LSB = 30;  localparam int B0_W = 4;
  localparam int B1_LSB = 34;  localparam int B1_W = 5;
  localparam int B2_LSB = 39;  localparam int B2_W = 6;
  localparam int B3_LSB = 45;  localparam int B3_W = 4;
  localparam int B4_LSB = 49;  localparam int B4_W = 5;
  localparam int B5_LSB = 54;  localparam int B5_W = 6;

  // One step of the Galois LFSR.
  function automatic logic [63:0] lfsr_next(input logic [63:0] s);
    logic [63:0] fb;
    if (s[0]) begin
      fb = LFSR_MASK;
    end else begin
      fb = 64'd0;
    end
    return (s >> 1) ^ fb;
  endfunction

  // Compress the 90-bit result bus into one 32-bit word.
  function automatic logic [31:0] misr_fold(input logic [89:0] y);
    return y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]};
  endfunction

  // One MISR step: CRC-style shift with the folded result mixed in.
  function automatic logic [31:0] misr_next(input logic [31:0] m, input logic [89:0] y);
    logic [31:0] fb;
    if (m[31]) begin
      fb = CRC_POLY;
    end else begin
      fb = 32'd0;
    end
    return {m[30:0], 1'b0} ^ fb ^ misr_fold(y);
  endfunction

endpackage

// File: rtl/expr_misr32.sv
// 32-bit multiple-input signature register compacting the 90-bit result bus.
module expr_misr32
  import expr_harness_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic        en,
  input  logic [89:0] y,
  output logic [31:0] sig
);

  logic [31:0] sig_r;

  // Signature register: init has priority over a capture step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sig_r <= 32'd0;
    end else if (init) begin
      sig_r <= MISR_INIT;
    end else if (en) begin
      sig_r <= misr_next(sig_r, y);
    end else begin
      sig_r <= sig_r;
    end
  end

  assign sig = sig_r;

endmodule

// File: rtl/expr_vector_harness.sv
// Stimulus driver (LFSR operands) and response compactor (MISR) for expression blocks.
module expr_vector_harness
  import expr_harness_pkg::*;
#(
  parameter logic [63:0] SEED          = 64'h1,
  parameter logic [15:0] NUM_VECTORS   = 16'd256,
  parameter int unsigned SETTLE_CYCLES = 32'd1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [15:0]        vec_count,
  output logic [31:0]        signature,
  output logic        [3:0]  a0,
  output logic        [4:0]  a1,
  output logic        [5:0]  a2,
  output logic signed [3:0]  a3,
  output logic signed [4:0]  a4,
  output logic signed [5:0]  a5,
  output logic        [3:0]  b0,
  output logic        [4:0]  b1,
  output logic        [5:0]  b2,
  output logic signed [3:0]  b3,
  output logic signed [4:0]  b4,
  output logic signed [5:0]  b5,
  input  logic [89:0]        y
);

  // A zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [63:0] SEED_EFF = (SEED == 64'd0) ? 64'd1 : SEED;
  localparam int CNT_W = (SETTLE_CYCLES > 32'd1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 32'd1);

  if (NUM_VECTORS == 16'd0) begin : g_bad_num_vectors
    $error("expr_vector_harness: NUM_VECTORS must be in 1..65535");
  end
  if (SETTLE_CYCLES == 32'd0) begin : g_bad_settle
    $error("expr_vector_harness: SETTLE_CYCLES must be at least 1");
  end

  state_t            state_r;
  state_t            next_state;
  logic [63:0]       lfsr_r;
  logic [15:0]       vec_count_r;
  logic [15:0]       vec_count_inc;
  logic [CNT_W-1:0]  settle_cnt_r;
  logic              busy_r;
  logic              done_r;
  logic              load_s;
  logic              capture_s;

  assign vec_count_inc = vec_count_r + 16'd1;

  // Next-state and run-control strobes.
  always_comb begin
    next_state = state_r;
    load_s     = 1'b0;
    capture_s  = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          next_state = ST_SETTLE;
          load_s     = 1'b1;
        end else begin
          next_state = state_r;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_r == SETTLE_LAST) begin
          next_state = ST_CAPTURE;
        end else begin
          next_state = ST_SETTLE;
        end
      end
      ST_CAPTURE: begin
        capture_s = 1'b1;
        if (vec_count_inc == NUM_VECTORS) begin
          next_state = ST_DONE;
        end else begin
          next_state = ST_SETTLE;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // State register plus registered busy/done flags derived from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state;
      busy_r  <= (next_state == ST_SETTLE) || (next_state == ST_CAPTURE);
      done_r  <= (next_state == ST_DONE);
    end
  end

  // Stimulus LFSR: seeded on start, stepped once per captured vector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_r <= 64'd0;
    end else if (load_s) begin
      lfsr_r <= SEED_EFF;
    end else if (capture_s) begin
      lfsr_r <= lfsr_next(lfsr_r);
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  // Vector counter: cleared on start, bumped on every capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vec_count_r <= 16'd0;
    end else if (load_s) begin
      vec_count_r <= 16'd0;
    end else if (capture_s) begin
      vec_count_r <= vec_count_inc;
    end else begin
      vec_count_r <= vec_count_r;
    end
  end

  // Settle counter: counts cycles in SETTLE, cleared on start and after each capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      settle_cnt_r <= '0;
    end else if (load_s || capture_s) begin
      settle_cnt_r <= '0;
    end else if (state_r == ST_SETTLE) begin
      settle_cnt_r <= settle_cnt_r + CNT_W'(1);
    end else begin
      settle_cnt_r <= settle_cnt_r;
    end
  end

  expr_misr32 u_misr (
    .clk   (clk),
    .reset (reset),
    .init  (load_s),
    .en    (capture_s),
    .y     (y),
    .sig   (signature)
  );

  assign busy      = busy_r;
  assign done      = done_r;
  assign vec_count = vec_count_r;

  // Operands are plain slices of the LFSR register, stable for a whole vector.
  assign a0 = lfsr_r[A0_LSB +: A0_W];
  assign a1 = lfsr_r[A1_LSB +: A1_W];
  assign a2 = lfsr_r[A2_LSB +: A2_W];
  assign a3 = $signed(lfsr_r[A3_LSB +: A3_W]);
  assign a4 = $signed(lfsr_r[A4_LSB +: A4_W]);
  assign a5 = $signed(lfsr_r[A5_LSB +: A5_W]);
  assign b0 = lfsr_r[B0_LSB +: B0_W];
  assign b1 = lfsr_r[B1_LSB +: B1_W];
  assign b2 = lfsr_r[B2_LSB +: B2_W];
  assign b3 = $signed(lfsr_r[B3_LSB +: B3_W]);
  assign b4 = $signed(lfsr_r[B4_LSB +: B4_W]);
  assign b5 = $signed(lfsr_r[B5_LSB +: B5_W]);

endmodule

// File: tb/tb_expr_vector_harness.sv
// Directed, table-driven bench for expr_vector_harness.
module tb_expr_vector_harness;

  localparam logic [89:0] Y_ZERO     = 90'd0;
  localparam logic [89:0] FAULT_MASK = 90'd1 << 70;

  logic        clk;
  logic        reset;
  logic [3:0]  start_v;
  logic        flip;
  int          n_checks;
  int          n_fail;

  wire [59:0]  ops_one, ops_two, ops_zero, ops_g;
  wire         busy_one, done_one, busy_two, done_two, busy_zero, done_zero, busy_g, done_g;
  wire [15:0]  cnt_one, cnt_two, cnt_zero, cnt_g;
  wire [31:0]  sig_one, sig_two, sig_zero, sig_g;
  logic [89:0] y_g;
  logic [31:0] model_sig;

  typedef struct {
    logic [59:0] ops;
    logic [15:0] count;
  } vec_t;
  vec_t tab [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Golden expression block fed from the operand buses.
  function automatic logic [89:0] expr_fn(input logic [59:0] s);
    logic [3:0] a0, b0, a3, b3;
    logic [4:0] a1, b1, a4, b4;
    logic [5:0] a2, b2;
    logic signed [5:0] a5, b5;
    int p;
    logic [31:0] lo, mid;
    logic [25:0] hi;
    a0 = s[3:0];   a1 = s[8:4];   a2 = s[14:9];  a3 = s[18:15]; a4 = s[23:19]; a5 = s[29:24];
    b0 = s[33:30]; b1 = s[38:34]; b2 = s[44:39]; b3 = s[48:45]; b4 = s[53:49]; b5 = s[59:54];
    p   = a5 * b5;
    lo  = {2'b10, a2, b2, a1, b1, a0, b0};
    mid = 32'(p);
    hi  = {8'(a2 + b2), a3, b3, a4, b4};
    return {hi, mid, lo};
  endfunction

  function automatic logic [63:0] m_lfsr(input logic [63:0] s);
    return (s >> 1) ^ (s[0] ? 64'hD800_0000_0000_0000 : 64'd0);
  endfunction

  function automatic logic [31:0] m_misr(input logic [31:0] m, input logic [89:0] y);
    logic [31:0] f;
    f = y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]};
    return {m[30:0], 1'b0} ^ (m[31] ? 32'h04C11DB7 : 32'd0) ^ f;
  endfunction

  always_comb begin
    y_g = expr_fn(ops_g) ^ ((flip && (cnt_g == 16'd10)) ? FAULT_MASK : Y_ZERO);
  end

  expr_vector_harness #(.SEED(64'h1), .NUM_VECTORS(16'd1), .SETTLE_CYCLES(1)) u_one (
    .clk(clk), .reset(reset), .start(start_v[0]), .busy(busy_one), .done(done_one),
    .vec_count(cnt_one), .signature(sig_one),
    .a0(ops_one[3:0]), .a1(ops_one[8:4]), .a2(ops_one[14:9]),
    .a3(ops_one[18:15]), .a4(ops_one[23:19]), .a5(ops_one[29:24]),
    .b0(ops_one[33:30]), .b1(ops_one[38:34]), .b2(ops_one[44:39]),
    .b3(ops_one[48:45]), .b4(ops_one[53:49]), .b5(ops_one[59:54]),
    .y(Y_ZERO));

  expr_vector_harness #(.SEED(64'h1), .NUM_VECTORS(16'd2), .SETTLE_CYCLES(1)) u_two (
    .clk(clk), .reset(reset), .start(start_v[1]), .busy(busy_two), .done(done_two),
    .vec_count(cnt_two), .signature(sig_two),
    .a0(ops_two[3:0]), .a1(ops_two[8:4]), .a2(ops_two[14:9]),
    .a3(ops_two[18:15]), .a4(ops_two[23:19]), .a5(ops_two[29:24]),
    .b0(ops_two[33:30]), .b1(ops_two[38:34]), .b2(ops_two[44:39]),
    .b3(ops_two[48:45]), .b4(ops_two[53:49]), .b5(ops_two[59:54]),
    .y(Y_ZERO));

  expr_vector_harness #(.SEED(64'h0), .NUM_VECTORS(16'd2), .SETTLE_CYCLES(1)) u_zero (
    .clk(clk), .reset(reset), .start(start_v[2]), .busy(busy_zero), .done(done_zero),
    .vec_count(cnt_zero), .signature(sig_zero),
    .a0(ops_zero[3:0]), .a1(ops_zero[8:4]), .a2(ops_zero[14:9]),
    .a3(ops_zero[18:15]), .a4(ops_zero[23:19]), .a5(ops_zero[29:24]),
    .b0(ops_zero[33:30]), .b1(ops_zero[38:34]), .b2(ops_zero[44:39]),
    .b3(ops_zero[48:45]), .b4(ops_zero[53:49]), .b5(ops_zero[59:54]),
    .y(Y_ZERO));

  expr_vector_harness #(.SEED(64'h1), .NUM_VECTORS(16'd256), .SETTLE_CYCLES(2)) u_gold (
    .clk(clk), .reset(reset), .start(start_v[3]), .busy(busy_g), .done(done_g),
    .vec_count(cnt_g), .signature(sig_g),
    .a0(ops_g[3:0]), .a1(ops_g[8:4]), .a2(ops_g[14:9]),
    .a3(ops_g[18:15]), .a4(ops_g[23:19]), .a5(ops_g[29:24]),
    .b0(ops_g[33:30]), .b1(ops_g[38:34]), .b2(ops_g[44:39]),
    .b3(ops_g[48:45]), .b4(ops_g[53:49]), .b5(ops_g[59:54]),
    .y(y_g));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_ne(input string name, input logic [63:0] act, input logic [63:0] bad);
    n_checks++;
    if (act === bad) begin
      n_fail++;
      $display("FAIL %s: got %h expected anything else", name, act);
    end
  endtask

  // Raise start for the masked instances across one rising edge; returns at the following negedge.
  task automatic pulse_start(input logic [3:0] mask);
    start_v = mask;
    @(posedge clk);
    #1 start_v = 4'b0000;
    @(negedge clk);
  endtask

  task automatic wait_gold_done;
    for (int i = 0; i < 1200 && !done_g; i++) @(negedge clk);
    check("gold_done_timeout", {63'd0, done_g}, 64'd1);
  endtask

  initial begin
    logic [63:0] s_m;
    n_checks = 0;
    n_fail   = 0;
    start_v  = 4'b0000;
    flip     = 1'b0;
    reset    = 1'b1;

    tab[0] = '{ops: 60'h1,                   count: 16'd0};
    tab[1] = '{ops: 60'h800_0000_0000_0000,  count: 16'd1};
    tab[2] = '{ops: 60'hC00_0000_0000_0000,  count: 16'd2};
    tab[3] = '{ops: 60'h600_0000_0000_0000,  count: 16'd3};

    s_m = 64'd1;
    model_sig = 32'hFFFF_FFFF;
    for (int k = 0; k < 256; k++) begin
      model_sig = m_misr(model_sig, expr_fn(s_m[59:0]));
      s_m = m_lfsr(s_m);
    end

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_ops",  {4'd0, ops_one}, 64'd0);
    check("rst_sig",  {32'd0, sig_one}, 64'd0);
    check("rst_busy", {63'd0, busy_one}, 64'd0);
    check("rst_done", {63'd0, done_one}, 64'd0);
    check("rst_cnt",  {48'd0, cnt_one}, 64'd0);
    check("rst_gold_ops", {4'd0, ops_g}, 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_no_start_busy", {63'd0, busy_one}, 64'd0);

    // Single vector, y=0.
    pulse_start(4'b0001);
    check("one_v0_ops",  {4'd0, ops_one}, 64'h1);
    check("one_v0_busy", {63'd0, busy_one}, 64'd1);
    check("one_v0_done", {63'd0, done_one}, 64'd0);
    check("one_v0_sig",  {32'd0, sig_one}, 64'hFFFF_FFFF);
    @(negedge clk);
    check("one_cap_busy", {63'd0, busy_one}, 64'd1);
    check("one_cap_done", {63'd0, done_one}, 64'd0);
    @(negedge clk);
    check("one_done",      {63'd0, done_one}, 64'd1);
    check("one_done_busy", {63'd0, busy_one}, 64'd0);
    check("one_sig",       {32'd0, sig_one}, 64'hFB3E_E249);
    check("one_cnt",       {48'd0, cnt_one}, 64'd1);
    repeat (2) @(negedge clk);
    check("one_hold_done", {63'd0, done_one}, 64'd1);
    check("one_hold_sig",  {32'd0, sig_one}, 64'hFB3E_E249);
    check("one_hold_ops",  {4'd0, ops_one}, 64'h800_0000_0000_0000);
    // Restart from DONE.
    pulse_start(4'b0001);
    check("one_re_done", {63'd0, done_one}, 64'd0);
    check("one_re_busy", {63'd0, busy_one}, 64'd1);
    check("one_re_sig",  {32'd0, sig_one}, 64'hFFFF_FFFF);
    check("one_re_cnt",  {48'd0, cnt_one}, 64'd0);
    repeat (2) @(negedge clk);
    check("one_re_final_done", {63'd0, done_one}, 64'd1);
    check("one_re_final_sig",  {32'd0, sig_one}, 64'hFB3E_E249);

    // Two vectors, SEED=1 and SEED=0, with a start pulse during SETTLE on u_two.
    pulse_start(4'b0110);
    check("two_v0_ops",  {4'd0, ops_two}, 64'h1);
    check("zero_v0_ops", {4'd0, ops_zero}, 64'h1);
    repeat (2) @(negedge clk);
    check("two_v1_ops",  {4'd0, ops_two}, 64'h800_0000_0000_0000);
    check("zero_v1_ops", {4'd0, ops_zero}, 64'h800_0000_0000_0000);
    check("two_v1_cnt",  {48'd0, cnt_two}, 64'd1);
    pulse_start(4'b0010);
    check("two_ign_busy", {63'd0, busy_two}, 64'd1);
    check("two_ign_done", {63'd0, done_two}, 64'd0);
    @(negedge clk);
    check("two_done",  {63'd0, done_two}, 64'd1);
    check("two_sig",   {32'd0, sig_two}, 64'hF2BC_D925);
    check("two_cnt",   {48'd0, cnt_two}, 64'd2);
    check("zero_done", {63'd0, done_zero}, 64'd1);
    check("zero_sig",  {32'd0, sig_zero}, 64'hF2BC_D925);
    check("zero_cnt",  {48'd0, cnt_zero}, 64'd2);

    // Golden expression run, SETTLE_CYCLES=2: per-vector operand table then signature.
    pulse_start(4'b1000);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) repeat (3) @(negedge clk);
      check($sformatf("gold_v%0d_ops", k), {4'd0, ops_g}, {4'd0, tab[k].ops});
      check($sformatf("gold_v%0d_cnt", k), {48'd0, cnt_g}, {48'd0, tab[k].count});
    end
    wait_gold_done();
    check("gold_sig", {32'd0, sig_g}, {32'd0, model_sig});
    check("gold_cnt", {48'd0, cnt_g}, 64'd256);

    // Same run with one corrupted result bit on vector 10.
    flip = 1'b1;
    pulse_start(4'b1000);
    wait_gold_done();
    check_ne("fault_sig", {32'd0, sig_g}, {32'd0, model_sig});
    flip = 1'b0;

    // Reset mid-run between clock edges.
    pulse_start(4'b1000);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_ops",  {4'd0, ops_g}, 64'd0);
    check("mid_rst_sig",  {32'd0, sig_g}, 64'd0);
    check("mid_rst_busy", {63'd0, busy_g}, 64'd0);
    check("mid_rst_done", {63'd0, done_g}, 64'd0);
    check("mid_rst_cnt",  {48'd0, cnt_g}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    pulse_start(4'b1000);
    check("fresh_ops",  {4'd0, ops_g}, 64'h1);
    check("fresh_sig",  {32'd0, sig_g}, 64'hFFFF_FFFF);
    check("fresh_busy", {63'd0, busy_g}, 64'd1);
    wait_gold_done();
    check("fresh_gold_sig", {32'd0, sig_g}, {32'd0, model_sig});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
